// File: rtl/imem_arbiter.sv
// Instruction-side memory port arbiter: the icache line refill and the PTW share one read port.
// Tie-breaking is fixed PTW priority by default; define IMEM_ARB_RR_EN for round-robin.
module imem_arbiter #(
  parameter int XLEN   = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_i,
  input  logic [XLEN-1:0]   ic_addr_i,
  input  logic              ic_kill_i,
  output logic              ic_ack_o,
  input  logic              ptw_req_i,
  input  logic [XLEN-1:0]   ptw_addr_i,
  output logic              ptw_ack_o,
  output logic [LINE_W-1:0] r_data_o,
  output logic              mem_req_o,
  output logic [XLEN-1:0]   mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              arb_busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IC  = 2'd1,
    GNT_PTW = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] mem_addr_reg, mem_addr_next;
  logic            last_gnt_reg, last_gnt_next;

  logic [XLEN-1:0] ic_line_addr;
  logic [XLEN-1:0] ptw_pte_addr;
  logic            ic_valid;
  logic            pick_ptw;
  logic            unused_addr_bits;

  // Line and PTE addresses are aligned on the bus; the low bits are don't-care.
  assign ic_line_addr     = {ic_addr_i[XLEN-1:4], 4'b0000};
  assign ptw_pte_addr     = {ptw_addr_i[XLEN-1:2], 2'b00};
  assign unused_addr_bits = ^{ic_addr_i[3:0], ptw_addr_i[1:0]};

  // A kill in the request cycle cancels the icache request before it is granted.
  assign ic_valid = ic_req_i & ~ic_kill_i;

`ifdef IMEM_ARB_RR_EN
  // last_gnt = 1 means PTW won last time, so the icache wins the next tie.
  assign pick_ptw = ptw_req_i & (~ic_valid | ~last_gnt_reg);
`else
  logic unused_last_gnt;
  assign pick_ptw        = ptw_req_i;
  assign unused_last_gnt = last_gnt_reg;
`endif

  always_comb begin
    state_next    = state_reg;
    mem_addr_next = mem_addr_reg;
    last_gnt_next = last_gnt_reg;
    ic_ack_o      = 1'b0;
    ptw_ack_o     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ptw_req_i || ic_valid) begin
          if (pick_ptw) begin
            state_next    = GNT_PTW;
            mem_addr_next = ptw_pte_addr;
            last_gnt_next = 1'b1;
          end else begin
            state_next    = GNT_IC;
            mem_addr_next = ic_line_addr;
            last_gnt_next = 1'b0;
          end
        end
      end
      GNT_IC: begin
        if (mem_ack_i) begin
          ic_ack_o   = ~ic_kill_i;
          state_next = IDLE;
        end else if (ic_kill_i) begin
          state_next = DRAIN;
        end
      end
      GNT_PTW: begin
        if (mem_ack_i) begin
          ptw_ack_o  = 1'b1;
          state_next = IDLE;
        end
      end
      DRAIN: begin
        // The request is already on the bus; wait out its response and drop it.
        if (mem_ack_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      mem_addr_reg <= '0;
      last_gnt_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      mem_addr_reg <= mem_addr_next;
      last_gnt_reg <= last_gnt_next;
    end
  end

  assign mem_req_o  = (state_reg != IDLE);
  assign arb_busy_o = (state_reg != IDLE);
  assign mem_addr_o = mem_addr_reg;
  assign r_data_o   = mem_data_i;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed vector table, tie/reset sequences, random vs. model.
module tb_imem_arbiter;

  logic         clk;
  logic         rst;
  logic         ic_req_i;
  logic [31:0]  ic_addr_i;
  logic         ic_kill_i;
  logic         ic_ack_o;
  logic         ptw_req_i;
  logic [31:0]  ptw_addr_i;
  logic         ptw_ack_o;
  logic [127:0] r_data_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_ack_i;
  logic [127:0] mem_data_i;
  logic         arb_busy_o;

  int n_vec  = 0;
  int n_fail = 0;

  imem_arbiter #(.XLEN(32), .LINE_W(128)) dut (
    .clk        (clk),
    .rst        (rst),
    .ic_req_i   (ic_req_i),
    .ic_addr_i  (ic_addr_i),
    .ic_kill_i  (ic_kill_i),
    .ic_ack_o   (ic_ack_o),
    .ptw_req_i  (ptw_req_i),
    .ptw_addr_i (ptw_addr_i),
    .ptw_ack_o  (ptw_ack_o),
    .r_data_o   (r_data_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_data_i (mem_data_i),
    .arb_busy_o (arb_busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        ic_req;
    logic        ic_kill;
    logic        ptw_req;
    logic        mem_ack;
    logic [31:0] ic_addr;
    logic [31:0] ptw_addr;
    logic        e_req;
    logic        e_ic_ack;
    logic        e_ptw_ack;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic icr, logic k, logic pr, logic ack, logic [31:0] ia,
                              logic [31:0] pa, logic er, logic eia, logic epa, logic [31:0] ea);
    vec_t v;
    v.ic_req = icr; v.ic_kill = k; v.ptw_req = pr; v.mem_ack = ack;
    v.ic_addr = ia; v.ptw_addr = pa;
    v.e_req = er; v.e_ic_ack = eia; v.e_ptw_ack = epa; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    ic_req_i   = 1'b0;
    ic_kill_i  = 1'b0;
    ptw_req_i  = 1'b0;
    mem_ack_i  = 1'b0;
    ic_addr_i  = '0;
    ptw_addr_i = '0;
    mem_data_i = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_ic_ack", ic_ack_o, 0);
    chk("rst_ptw_ack", ptw_ack_o, 0);
    chk("rst_busy", arb_busy_o, 0);
    rst = 1'b0;
  endtask

  // Behavioural reference: one outstanding transaction described by owner/killed/address.
  bit          m_busy, m_is_ptw, m_killed, m_last_ptw;
  logic [31:0] m_addr;

  task automatic model_reset();
    m_busy = 0; m_is_ptw = 0; m_killed = 0; m_last_ptw = 1; m_addr = '0;
  endtask

  task automatic model_step();
    bit want_ic, take_ptw;
    if (m_busy) begin
      if (mem_ack_i) m_busy = 0;
      else if (!m_is_ptw && ic_kill_i) m_killed = 1;
    end else begin
      want_ic = ic_req_i && !ic_kill_i;
      if (ptw_req_i || want_ic) begin
`ifdef IMEM_ARB_RR_EN
        take_ptw = (ptw_req_i && want_ic) ? !m_last_ptw : ptw_req_i;
`else
        take_ptw = ptw_req_i;
`endif
        m_busy = 1; m_killed = 0; m_is_ptw = take_ptw; m_last_ptw = take_ptw;
        m_addr = take_ptw ? (ptw_addr_i & 32'hFFFF_FFFC) : (ic_addr_i & 32'hFFFF_FFF0);
      end
    end
  endtask

  initial begin
    bit exp_ptw;
    int grant_no;

    rst = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
    do_reset();

    //        icr k  pr ack ic_addr       ptw_addr      req ica pta addr
    vecs[0]  = mk(1, 0, 0, 0, 32'h8000_0014, 32'h0,        0, 0, 0, 32'h0);
    vecs[1]  = mk(1, 0, 0, 0, 32'h8000_0014, 32'h0,        1, 0, 0, 32'h8000_0010);
    vecs[2]  = mk(1, 0, 0, 0, 32'h8000_0014, 32'h0,        1, 0, 0, 32'h8000_0010);
    vecs[3]  = mk(1, 0, 0, 0, 32'h8000_0014, 32'h0,        1, 0, 0, 32'h8000_0010);
    vecs[4]  = mk(1, 0, 0, 1, 32'h8000_0014, 32'h0,        1, 1, 0, 32'h8000_0010);
    vecs[5]  = mk(0, 0, 0, 0, 32'h0,         32'h0,        0, 0, 0, 32'h8000_0010);
    vecs[6]  = mk(1, 0, 0, 0, 32'h1234_5678, 32'h0,        0, 0, 0, 32'h8000_0010);
    vecs[7]  = mk(0, 1, 0, 0, 32'h1234_5678, 32'h0,        1, 0, 0, 32'h1234_5670);
    vecs[8]  = mk(0, 0, 0, 0, 32'h0,         32'h0,        1, 0, 0, 32'h1234_5670);
    vecs[9]  = mk(0, 1, 0, 0, 32'h0,         32'h0,        1, 0, 0, 32'h1234_5670);
    vecs[10] = mk(0, 0, 0, 0, 32'h0,         32'h0,        1, 0, 0, 32'h1234_5670);
    vecs[11] = mk(0, 0, 0, 1, 32'h0,         32'h0,        1, 0, 0, 32'h1234_5670);
    vecs[12] = mk(0, 0, 0, 0, 32'h0,         32'h0,        0, 0, 0, 32'h1234_5670);
    vecs[13] = mk(1, 0, 0, 0, 32'h0000_0020, 32'h0,        0, 0, 0, 32'h1234_5670);
    vecs[14] = mk(1, 1, 0, 1, 32'h0000_0020, 32'h0,        1, 0, 0, 32'h0000_0020);
    vecs[15] = mk(0, 0, 0, 0, 32'h0,         32'h0,        0, 0, 0, 32'h0000_0020);
    vecs[16] = mk(1, 1, 0, 0, 32'h0000_0040, 32'h0,        0, 0, 0, 32'h0000_0020);
    vecs[17] = mk(0, 0, 0, 1, 32'h0,         32'h0,        0, 0, 0, 32'h0000_0020);
    vecs[18] = mk(0, 0, 1, 0, 32'h0,         32'h0000_1007, 0, 0, 0, 32'h0000_0020);
    vecs[19] = mk(0, 1, 1, 0, 32'h0,         32'hFFFF_FFFF, 1, 0, 0, 32'h0000_1004);
    vecs[20] = mk(0, 0, 1, 1, 32'h0,         32'hFFFF_FFFF, 1, 0, 1, 32'h0000_1004);
    vecs[21] = mk(0, 0, 0, 0, 32'h0,         32'h0,        0, 0, 0, 32'h0000_1004);

    for (int i = 0; i < 22; i++) begin
      ic_req_i   = vecs[i].ic_req;
      ic_kill_i  = vecs[i].ic_kill;
      ptw_req_i  = vecs[i].ptw_req;
      mem_ack_i  = vecs[i].mem_ack;
      ic_addr_i  = vecs[i].ic_addr;
      ptw_addr_i = vecs[i].ptw_addr;
      mem_data_i = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk($sformatf("tbl%0d_mem_req", i), mem_req_o, vecs[i].e_req);
      chk($sformatf("tbl%0d_busy", i), arb_busy_o, vecs[i].e_req);
      chk($sformatf("tbl%0d_ic_ack", i), ic_ack_o, vecs[i].e_ic_ack);
      chk($sformatf("tbl%0d_ptw_ack", i), ptw_ack_o, vecs[i].e_ptw_ack);
      chk($sformatf("tbl%0d_mem_addr", i), mem_addr_o, vecs[i].e_addr);
      chk($sformatf("tbl%0d_r_data", i), r_data_o, mem_data_i);
      @(posedge clk);
      #1;
    end

    // Tie: both requesters held high, memory answers every grant cycle.
    do_reset();
    grant_no = 0;
    for (int c = 0; c < 8; c++) begin
      ic_req_i   = 1'b1;
      ptw_req_i  = 1'b1;
      ic_addr_i  = 32'h0000_0100;
      ptw_addr_i = 32'h0000_0200;
      mem_ack_i  = (c % 2 == 1);
      @(negedge clk);
      if (c % 2 == 0) begin
        chk($sformatf("tie%0d_idle_gap", c), arb_busy_o, 0);
      end else begin
`ifdef IMEM_ARB_RR_EN
        exp_ptw = (grant_no % 2 == 1);
`else
        exp_ptw = 1'b1;
`endif
        chk($sformatf("tie%0d_ic_ack", c), ic_ack_o, !exp_ptw);
        chk($sformatf("tie%0d_ptw_ack", c), ptw_ack_o, exp_ptw);
        chk($sformatf("tie%0d_mem_addr", c), mem_addr_o, exp_ptw ? 32'h200 : 32'h100);
        grant_no++;
      end
      @(posedge clk);
      #1;
    end

    // Reset asserted while a PTW read is outstanding.
    drive_idle();
    ptw_req_i  = 1'b1;
    ptw_addr_i = 32'hABCD_0003;
    @(negedge clk);
    chk("rstptw_pre_req", mem_req_o, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstptw_gnt_req", mem_req_o, 1);
    chk("rstptw_gnt_addr", mem_addr_o, 32'hABCD_0000);
    @(posedge clk);
    #1;
    mem_ack_i = 1'b1;
    rst = 1'b1;
    #1;
    chk("rstptw_req", mem_req_o, 0);
    chk("rstptw_busy", arb_busy_o, 0);
    chk("rstptw_addr", mem_addr_o, 0);
    chk("rstptw_ptw_ack", ptw_ack_o, 0);
    chk("rstptw_ic_ack", ic_ack_o, 0);
    @(negedge clk);
    rst = 1'b0;
    ptw_req_i = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("stray_ptw_ack", ptw_ack_o, 0);
    chk("stray_ic_ack", ic_ack_o, 0);
    chk("stray_busy", arb_busy_o, 0);
    @(posedge clk);
    #1;

    // Random stimulus against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      ic_req_i   = ($urandom_range(1, 0) == 1);
      ic_kill_i  = ($urandom_range(7, 0) == 0);
      ptw_req_i  = ($urandom_range(9, 0) < 4);
      mem_ack_i  = ($urandom_range(2, 0) == 0);
      ic_addr_i  = $urandom;
      ptw_addr_i = $urandom;
      mem_data_i = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("rnd_mem_req", mem_req_o, m_busy);
      chk("rnd_busy", arb_busy_o, m_busy);
      chk("rnd_mem_addr", mem_addr_o, m_addr);
      chk("rnd_ic_ack", ic_ack_o, m_busy && !m_is_ptw && !m_killed && mem_ack_i && !ic_kill_i);
      chk("rnd_ptw_ack", ptw_ack_o, m_busy && m_is_ptw && mem_ack_i);
      chk("rnd_r_data", r_data_o, mem_data_i);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
